// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit load/store to a 16-bit external SRAM, two 2-cycle halfword phases per access.
// Optional stall counter output is enabled by defining SRAM_STALL_COUNTER_EN.
module sram_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_W_EN,
  input  logic        MEM_R_EN,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  output logic [17:0] SRAM_ADDR,
  output logic [15:0] SRAM_DQ_out,
  input  logic [15:0] SRAM_DQ_in,
  output logic        SRAM_DQ_oe,
  output logic        SRAM_WE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
`ifdef SRAM_STALL_COUNTER_EN
  ,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t      state;
  logic        phase;
  logic        is_write;
  logic [16:0] index;
  logic [31:0] wdata;
  logic        req;
  logic [31:0] offset;
  logic [16:0] req_index;
  logic        unused_offset_bits;

  assign req                = MEM_W_EN | MEM_R_EN;
  assign offset             = address - 32'd1024;
  assign req_index          = offset[18:2];
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  always_comb begin
    ready = 1'b0;
    case (state)
      IDLE:    ready = ~req;
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // Pad outputs are registered from the next state, so they line up with LOW/HIGH cycles exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      phase       <= 1'b0;
      is_write    <= 1'b0;
      index       <= '0;
      wdata       <= '0;
      readData    <= '0;
      SRAM_ADDR   <= '0;
      SRAM_DQ_out <= '0;
      SRAM_DQ_oe  <= 1'b0;
      SRAM_WE_N   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state       <= LOW;
            phase       <= 1'b0;
            is_write    <= MEM_W_EN;
            index       <= req_index;
            wdata       <= writeData;
            SRAM_ADDR   <= {req_index, 1'b0};
            SRAM_DQ_out <= MEM_W_EN ? writeData[15:0] : 16'h0000;
            SRAM_DQ_oe  <= MEM_W_EN;
            SRAM_WE_N   <= ~MEM_W_EN;
          end
        end
        LOW: begin
          if (!phase) begin
            phase <= 1'b1;
          end else begin
            phase       <= 1'b0;
            state       <= HIGH;
            SRAM_ADDR   <= {index, 1'b1};
            SRAM_DQ_out <= is_write ? wdata[31:16] : 16'h0000;
            if (!is_write) readData[15:0] <= SRAM_DQ_in;
          end
        end
        HIGH: begin
          if (!phase) begin
            phase <= 1'b1;
          end else begin
            phase       <= 1'b0;
            state       <= DONE;
            SRAM_ADDR   <= '0;
            SRAM_DQ_out <= '0;
            SRAM_DQ_oe  <= 1'b0;
            SRAM_WE_N   <= 1'b1;
            if (!is_write) readData[31:16] <= SRAM_DQ_in;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SRAM_STALL_COUNTER_EN
  always_ff @(posedge clk) begin
    if (rst) stall_count <= '0;
    else if (!ready) stall_count <= stall_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - scoreboard bench for sram_controller with a behavioural 16-bit SRAM.
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_W_EN, MEM_R_EN;
  logic [31:0] address, writeData, readData;
  logic        ready;
  logic [17:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_out, SRAM_DQ_in;
  logic        SRAM_DQ_oe, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N;
`ifdef SRAM_STALL_COUNTER_EN
  logic [31:0] stall_count;
`endif

  always #5 clk = ~clk;

  sram_controller dut (
`ifdef SRAM_STALL_COUNTER_EN
    .stall_count(stall_count),
`endif
    .clk(clk), .rst(rst), .MEM_W_EN(MEM_W_EN), .MEM_R_EN(MEM_R_EN),
    .address(address), .writeData(writeData), .readData(readData), .ready(ready),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_out(SRAM_DQ_out), .SRAM_DQ_in(SRAM_DQ_in),
    .SRAM_DQ_oe(SRAM_DQ_oe), .SRAM_WE_N(SRAM_WE_N), .SRAM_CE_N(SRAM_CE_N),
    .SRAM_OE_N(SRAM_OE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
  );

  logic [15:0] mem [0:262143];
  assign SRAM_DQ_in = mem[SRAM_ADDR];
  always @(posedge clk) if (SRAM_WE_N === 1'b0) mem[SRAM_ADDR] <= SRAM_DQ_out;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  typedef struct {logic [17:0] addr; logic [15:0] data;} beat_t;
  typedef struct {logic [31:0] rdata; string name;} done_t;
  beat_t wq[$];
  done_t cq[$];
  beat_t b;
  done_t d;

  task automatic push_write(input logic [17:0] lo_addr, input logic [31:0] data);
    for (int i = 0; i < 2; i++) wq.push_back('{lo_addr, data[15:0]});
    for (int i = 0; i < 2; i++) wq.push_back('{lo_addr + 18'd1, data[31:16]});
  endtask

  // Monitor: every write beat and every busy->ready completion is checked against the queues.
  int   busy_cnt = 0;
  logic prev_ready = 1'b1;
  logic prev_rst = 1'b1;
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (SRAM_WE_N === 1'b0) begin
        if (wq.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_write_beat: actual addr=0x%0h data=0x%0h required=none", SRAM_ADDR, SRAM_DQ_out);
        end else begin
          b = wq.pop_front();
          chk("wbeat_addr", {46'd0, SRAM_ADDR}, {46'd0, b.addr});
          chk("wbeat_data", {48'd0, SRAM_DQ_out}, {48'd0, b.data});
          chk("wbeat_oe", {63'd0, SRAM_DQ_oe}, 64'd1);
        end
      end
      if (ready !== 1'b1) begin
        busy_cnt++;
      end else if (prev_ready === 1'b0 && prev_rst === 1'b0) begin
        if (cq.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_completion: actual readData=0x%0h required=none", readData);
        end else begin
          d = cq.pop_front();
          chk({d.name, "_rdata"}, {32'd0, readData}, {32'd0, d.rdata});
          chk({d.name, "_busy_cycles"}, 64'(busy_cnt), 64'd5);
        end
        busy_cnt = 0;
      end
    end
    prev_ready = ready;
    prev_rst   = rst;
  end

  task automatic access(input logic w, input logic r, input logic [31:0] a, input logic [31:0] wd,
                        output int edges);
    MEM_W_EN = w; MEM_R_EN = r; address = a; writeData = wd;
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
    end while (ready !== 1'b1 && edges < 20);
    if (ready !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL access_timeout: actual ready=%b required=1 within 20 cycles", ready);
    end
  endtask

  task automatic go_idle();
    MEM_W_EN = 1'b0; MEM_R_EN = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  int e1, e2;

  initial begin
    for (int i = 0; i < 262144; i++) mem[i] = 16'h0000;
    mem[4] = 16'h0BAD;
    mem[5] = 16'hF00D;
    rst = 1'b1; MEM_W_EN = 1'b0; MEM_R_EN = 1'b0; address = '0; writeData = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset_ready", {63'd0, ready}, 64'd1);
    chk("reset_we_n", {63'd0, SRAM_WE_N}, 64'd1);
    chk("reset_oe", {63'd0, SRAM_DQ_oe}, 64'd0);
    chk("reset_addr", {46'd0, SRAM_ADDR}, 64'd0);
    chk("reset_rdata", {32'd0, readData}, 64'd0);
    chk("const_pins", {60'd0, SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N}, 64'd0);

    push_write(18'd2, 32'hDEADBEEF);
    cq.push_back('{32'h0000_0000, "write"});
    access(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, e1);
    chk("write_edges", 64'(e1), 64'd5);
    go_idle();

    cq.push_back('{32'hDEADBEEF, "read"});
    access(1'b0, 1'b1, 32'd1028, 32'h0, e1);
    chk("read_edges", 64'(e1), 64'd5);
    chk("read_done_we_n", {63'd0, SRAM_WE_N}, 64'd1);
    go_idle();

    push_write(18'd0, 32'h12345678);
    cq.push_back('{32'hDEADBEEF, "both_en"});
    access(1'b1, 1'b1, 32'd1024, 32'h12345678, e1);
    go_idle();

    push_write(18'h3FE00, 32'hA5A55A5A);
    cq.push_back('{32'hDEADBEEF, "wrap"});
    access(1'b1, 1'b0, 32'd0, 32'hA5A55A5A, e1);
    go_idle();

    wq.push_back('{18'd8, 16'hF00D});
    wq.push_back('{18'd8, 16'hF00D});
    MEM_W_EN = 1'b1; address = 32'd1040; writeData = 32'hCAFEF00D;
    repeat (3) begin @(posedge clk); #1; end
    chk("midwrite_high_addr", {46'd0, SRAM_ADDR}, 64'd9);
    chk("midwrite_high_we_n", {63'd0, SRAM_WE_N}, 64'd0);
    rst = 1'b1; MEM_W_EN = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midwrite_rst_we_n", {63'd0, SRAM_WE_N}, 64'd1);
    chk("midwrite_rst_oe", {63'd0, SRAM_DQ_oe}, 64'd0);
    chk("midwrite_rst_rdata", {32'd0, readData}, 64'd0);
    chk("midwrite_rst_ready", {63'd0, ready}, 64'd1);
    chk("midwrite_rst_addr", {46'd0, SRAM_ADDR}, 64'd0);
`ifdef SRAM_STALL_COUNTER_EN
    chk("stall_count_reset", {32'd0, stall_count}, 64'd0);
`endif

    cq.push_back('{32'h12345678, "b2b_first"});
    cq.push_back('{32'hF00D0BAD, "b2b_second"});
    access(1'b0, 1'b1, 32'd1024, 32'h0, e1);
    access(1'b0, 1'b1, 32'd1032, 32'h0, e2);
    chk("b2b_total_edges", 64'(e1 + e2), 64'd11);
`ifdef SRAM_STALL_COUNTER_EN
    chk("stall_count_two_accesses", {32'd0, stall_count}, 64'd10);
`endif
    go_idle();
    repeat (3) go_idle();

    chk("write_queue_drained", 64'(wq.size()), 64'd0);
    chk("completion_queue_drained", 64'(cq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
